// File: rtl/sic1_mmio_memory.sv
`default_nettype none
// ============================================================================
// Module      : sic1_mmio_memory
// Description : Unified SIC-1 memory. RAM in the low part of the address
//               space, memory-mapped input channels (1-entry buffers) and
//               output channels (holding registers) just below the top
//               address, which is reserved. Raises stall for reads of an
//               empty input channel or writes to a full output channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sic1_mmio_memory #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int NUM_IN  = 1,
  parameter int NUM_OUT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      stall,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready
);

  // First I/O address; everything below it is RAM.
  localparam int IO_BASE = (2 ** ADDR_W) - 1 - NUM_IN - NUM_OUT;
  localparam logic [ADDR_W-1:0] c_io_base = ADDR_W'(IO_BASE);

  logic [DATA_W-1:0]        r_mem [0:IO_BASE-1];
  logic [NUM_IN-1:0]        r_in_full;
  logic [NUM_IN*DATA_W-1:0] r_in_buf;
  logic [NUM_IN-1:0]        w_in_sel;
  logic [NUM_IN-1:0]        w_in_empty_rd;
  logic [NUM_IN-1:0]        w_in_pop;
  logic [NUM_OUT-1:0]       w_out_blocked;
  logic                     w_ram_sel;

  assign w_ram_sel = (addr < c_io_base);

  // Stall only for the two blocking cases; RAM and reserved never stall.
  assign stall = (|w_in_empty_rd) | (|w_out_blocked);

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en && w_ram_sel) begin
      r_mem[addr] <= data_in;
    end
  end

  genvar k;
  for (k = 0; k < NUM_IN; k++) begin : g_in
    localparam logic [ADDR_W-1:0] c_in_addr = ADDR_W'(IO_BASE + k);
    logic              r_full;
    logic [DATA_W-1:0] r_buf;

    assign w_in_sel[k]      = (addr == c_in_addr);
    assign w_in_empty_rd[k] = rd_en & w_in_sel[k] & ~r_full;
    assign w_in_pop[k]      = rd_en & w_in_sel[k] & r_full & ~stall;
    // Held low during reset so producers never push into a buffer being cleared.
    assign in_ready[k]      = rst_n & ~r_full;
    assign r_in_full[k]     = r_full;
    assign r_in_buf[k*DATA_W +: DATA_W] = r_buf;

    // Input buffer: push when empty and offered, pop on a non-stalled core read.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_full <= 1'b0;
        r_buf  <= '0;
      end else if (in_valid[k] && in_ready[k]) begin
        r_full <= 1'b1;
        r_buf  <= in_data[k*DATA_W +: DATA_W];
      end else if (w_in_pop[k]) begin
        r_full <= 1'b0;
      end
    end
  end

  genvar j;
  for (j = 0; j < NUM_OUT; j++) begin : g_out
    localparam logic [ADDR_W-1:0] c_out_addr = ADDR_W'(IO_BASE + NUM_IN + j);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_sel;
    logic              w_accept;

    assign w_sel            = wr_en & (addr == c_out_addr);
    // A write lands when the register is empty or is draining this cycle.
    assign w_accept         = w_sel & (~r_valid | out_ready[j]);
    assign w_out_blocked[j] = w_sel & r_valid & ~out_ready[j];
    assign out_valid[j]     = r_valid;
    assign out_data[j*DATA_W +: DATA_W] = r_data;

    // Holding register: a new write wins over a same-cycle transfer.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= data_in;
      end else if (r_valid && out_ready[j]) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; output and reserved addresses read as zero.
  always_comb begin
    data_out = '0;
    if (w_ram_sel) begin
      data_out = r_mem[addr];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_in_sel[i] && r_in_full[i]) begin
        data_out = r_in_buf[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sic1_mmio_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_sic1_mmio_memory
// Description : Directed self-checking bench for sic1_mmio_memory in three
//               configurations: default, 2-in/2-out, and 10-bit/16-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sic1_mmio_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Default configuration: RAM 0..252, in @253, out @254.
  logic [7:0] addr1 = '0;
  logic       rd_en1 = 1'b0, wr_en1 = 1'b0;
  logic [7:0] data_in1 = '0, data_out1;
  logic       stall1;
  logic [7:0] in_data1 = '0;
  logic       in_valid1 = 1'b0, in_ready1;
  logic [7:0] out_data1;
  logic       out_valid1, out_ready1 = 1'b0;

  sic1_mmio_memory u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .rd_en(rd_en1), .wr_en(wr_en1),
    .data_in(data_in1), .data_out(data_out1), .stall(stall1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  // Two inputs, two outputs: IO_BASE = 251.
  logic [7:0]  addr2 = '0;
  logic        rd_en2 = 1'b0, wr_en2 = 1'b0;
  logic [7:0]  data_in2 = '0, data_out2;
  logic        stall2;
  logic [15:0] in_data2 = '0;
  logic [1:0]  in_valid2 = '0, in_ready2;
  logic [15:0] out_data2;
  logic [1:0]  out_valid2, out_ready2 = '0;

  sic1_mmio_memory #(.DATA_W(8), .ADDR_W(8), .NUM_IN(2), .NUM_OUT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr2), .rd_en(rd_en2), .wr_en(wr_en2),
    .data_in(data_in2), .data_out(data_out2), .stall(stall2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  // Wide configuration: IO_BASE = 1021.
  logic [9:0]  addr3 = '0;
  logic        rd_en3 = 1'b0, wr_en3 = 1'b0;
  logic [15:0] data_in3 = '0, data_out3;
  logic        stall3;
  logic [15:0] in_data3 = '0;
  logic        in_valid3 = 1'b0, in_ready3;
  logic [15:0] out_data3;
  logic        out_valid3, out_ready3 = 1'b0;

  sic1_mmio_memory #(.DATA_W(16), .ADDR_W(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .addr(addr3), .rd_en(rd_en3), .wr_en(wr_en3),
    .data_in(data_in3), .data_out(data_out3), .stall(stall3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  // Advance one clock and move 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready1);
    end
    n_checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== 8'h00) begin
      n_fail++; $display("FAIL reset_out: got valid=%b data=%h expected 0/00", out_valid1, out_data1);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready1 !== 1'b1 || stall1 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got in_ready=%b stall=%b expected 1/0", in_ready1, stall1);
    end
  endtask

  task automatic test_ram();
    wr_en1 = 1'b1; addr1 = 8'd0; data_in1 = 8'h5A;
    tick();
    addr1 = 8'd252; data_in1 = 8'hC3;
    tick();
    wr_en1 = 1'b0; rd_en1 = 1'b1; addr1 = 8'd0;
    #1;
    n_checks++;
    if (data_out1 !== 8'h5A) begin
      n_fail++; $display("FAIL ram_rd0: got %h expected 5a", data_out1);
    end
    addr1 = 8'd252;
    #1;
    n_checks++;
    if (data_out1 !== 8'hC3) begin
      n_fail++; $display("FAIL ram_rd252: got %h expected c3", data_out1);
    end
    addr1 = 8'd255;
    #1;
    n_checks++;
    if (data_out1 !== 8'h00 || stall1 !== 1'b0) begin
      n_fail++; $display("FAIL rd_reserved: got data=%h stall=%b expected 00/0", data_out1, stall1);
    end
    rd_en1 = 1'b0; wr_en1 = 1'b1; data_in1 = 8'h11; addr1 = 8'd255;
    #1;
    n_checks++;
    if (stall1 !== 1'b0) begin
      n_fail++; $display("FAIL wr_reserved_stall: got %b expected 0", stall1);
    end
    tick();
    addr1 = 8'd253;
    #1;
    n_checks++;
    if (stall1 !== 1'b0) begin
      n_fail++; $display("FAIL wr_input_stall: got %b expected 0", stall1);
    end
    tick();
    wr_en1 = 1'b0; addr1 = 8'd255;
    #1;
    n_checks++;
    if (data_out1 !== 8'h00 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL ignored_writes: got data=%h in_ready=%b out_valid=%b expected 00/1/0",
                         data_out1, in_ready1, out_valid1);
    end
    addr1 = 8'd253;
    #1;
    n_checks++;
    if (data_out1 !== 8'h00) begin
      n_fail++; $display("FAIL input_after_wr: got %h expected 00", data_out1);
    end
  endtask

  task automatic test_input();
    in_valid1 = 1'b1; in_data1 = 8'h42;
    tick();
    in_valid1 = 1'b0; in_data1 = 8'h00;
    n_checks++;
    if (in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL in_full_ready: got %b expected 0", in_ready1);
    end
    rd_en1 = 1'b1; addr1 = 8'd253;
    #1;
    n_checks++;
    if (data_out1 !== 8'h42 || stall1 !== 1'b0) begin
      n_fail++; $display("FAIL in_pop: got data=%h stall=%b expected 42/0", data_out1, stall1);
    end
    tick();
    rd_en1 = 1'b0;
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL in_ready_after_pop: got %b expected 1", in_ready1);
    end
    rd_en1 = 1'b1;
    #1;
    n_checks++;
    if (stall1 !== 1'b1 || data_out1 !== 8'h00) begin
      n_fail++; $display("FAIL in_empty_rd: got stall=%b data=%h expected 1/00", stall1, data_out1);
    end
    tick();
    rd_en1 = 1'b0;
  endtask

  task automatic test_output();
    out_ready1 = 1'b0; wr_en1 = 1'b1; addr1 = 8'd254; data_in1 = 8'h7E;
    #1;
    n_checks++;
    if (stall1 !== 1'b0) begin
      n_fail++; $display("FAIL out_first_wr_stall: got %b expected 0", stall1);
    end
    tick();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'h7E) begin
      n_fail++; $display("FAIL out_wr: got valid=%b data=%h expected 1/7e", out_valid1, out_data1);
    end
    data_in1 = 8'h01;
    #1;
    n_checks++;
    if (stall1 !== 1'b1) begin
      n_fail++; $display("FAIL out_blocked_stall: got %b expected 1", stall1);
    end
    tick();
    n_checks++;
    if (out_data1 !== 8'h7E || out_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL out_blocked_hold: got valid=%b data=%h expected 1/7e", out_valid1, out_data1);
    end
    out_ready1 = 1'b1;
    #1;
    n_checks++;
    if (stall1 !== 1'b0) begin
      n_fail++; $display("FAIL out_ready_unstall: got %b expected 0", stall1);
    end
    tick();
    wr_en1 = 1'b0;
    n_checks++;
    if (out_data1 !== 8'h01 || out_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL out_coincide: got valid=%b data=%h expected 1/01", out_valid1, out_data1);
    end
    tick();
    out_ready1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== 8'h01) begin
      n_fail++; $display("FAIL out_drain: got valid=%b data=%h expected 0/01", out_valid1, out_data1);
    end
    rd_en1 = 1'b1;
    #1;
    n_checks++;
    if (data_out1 !== 8'h00 || stall1 !== 1'b0) begin
      n_fail++; $display("FAIL rd_output_addr: got data=%h stall=%b expected 00/0", data_out1, stall1);
    end
    rd_en1 = 1'b0;
  endtask

  task automatic test_multi();
    in_valid2 = 2'b11; in_data2 = 16'hA1A0;
    tick();
    in_valid2 = 2'b00; in_data2 = 16'h0000;
    n_checks++;
    if (in_ready2 !== 2'b00) begin
      n_fail++; $display("FAIL multi_in_ready: got %b expected 00", in_ready2);
    end
    addr2 = 8'd251;
    #1;
    n_checks++;
    if (data_out2 !== 8'hA0) begin
      n_fail++; $display("FAIL multi_rd251: got %h expected a0", data_out2);
    end
    addr2 = 8'd252;
    #1;
    n_checks++;
    if (data_out2 !== 8'hA1) begin
      n_fail++; $display("FAIL multi_rd252: got %h expected a1", data_out2);
    end
    wr_en2 = 1'b1; addr2 = 8'd253; data_in2 = 8'h55;
    tick();
    n_checks++;
    if (out_valid2 !== 2'b01 || out_data2 !== 16'h0055) begin
      n_fail++; $display("FAIL multi_out0: got valid=%b data=%h expected 01/0055", out_valid2, out_data2);
    end
    addr2 = 8'd254; data_in2 = 8'h66;
    tick();
    wr_en2 = 1'b0;
    n_checks++;
    if (out_valid2 !== 2'b11 || out_data2 !== 16'h6655) begin
      n_fail++; $display("FAIL multi_out1: got valid=%b data=%h expected 11/6655", out_valid2, out_data2);
    end
  endtask

  task automatic test_reset_mid();
    in_valid1 = 1'b1; in_data1 = 8'h99;
    wr_en1 = 1'b1; addr1 = 8'd254; data_in1 = 8'h33; out_ready1 = 1'b0;
    tick();
    in_valid1 = 1'b0; wr_en1 = 1'b0;
    n_checks++;
    if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_loaded: got in_ready=%b out_valid=%b expected 0/1", in_ready1, out_valid1);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_ready_rst: got %b expected 0", in_ready1);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== 8'h00 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_after: got valid=%b data=%h in_ready=%b expected 0/00/1",
                         out_valid1, out_data1, in_ready1);
    end
    rd_en1 = 1'b1; addr1 = 8'd253;
    #1;
    n_checks++;
    if (stall1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_empty_rd: got %b expected 1", stall1);
    end
    addr1 = 8'd0;
    #1;
    n_checks++;
    if (data_out1 !== 8'h5A) begin
      n_fail++; $display("FAIL mid_ram_kept: got %h expected 5a", data_out1);
    end
    rd_en1 = 1'b0;
    tick();
  endtask

  task automatic test_wide();
    wr_en3 = 1'b1; addr3 = 10'd1020; data_in3 = 16'hBEEF;
    tick();
    wr_en3 = 1'b0; rd_en3 = 1'b1;
    #1;
    n_checks++;
    if (data_out3 !== 16'hBEEF) begin
      n_fail++; $display("FAIL wide_ram: got %h expected beef", data_out3);
    end
    rd_en3 = 1'b0;
    in_valid3 = 1'b1; in_data3 = 16'h1234;
    tick();
    in_valid3 = 1'b0;
    rd_en3 = 1'b1; addr3 = 10'd1021;
    #1;
    n_checks++;
    if (data_out3 !== 16'h1234 || stall3 !== 1'b0) begin
      n_fail++; $display("FAIL wide_input: got data=%h stall=%b expected 1234/0", data_out3, stall3);
    end
    rd_en3 = 1'b0; addr3 = 10'd1023;
    #1;
    n_checks++;
    if (data_out3 !== 16'h0000) begin
      n_fail++; $display("FAIL wide_reserved: got %h expected 0000", data_out3);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_input();
    test_output();
    test_multi();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sic1_mmio_memory.md
Name: sic1_mmio_memory

Overview:
- Parametrised unified memory for the SIC-1 core: RAM plus memory-mapped input and output channels at the top of the address space.
- Each input channel has a 1-entry buffer with a valid/ready handshake. Each output channel has a holding register with a valid/ready handshake.
- Asserts `stall` to the core when it reads an empty input channel or writes a full output channel.
- Default parameters give RAM 0..252, input at 253, output at 254 and 255 reserved.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 8, address width.
- NUM_IN, 1, number of input channels (1..8).
- NUM_OUT, 1, number of output channels (1..8).
- Derived (localparam): IO_BASE = 2^ADDR_W - 1 - NUM_IN - NUM_OUT.
  - RAM: 0..IO_BASE-1.
  - Input k: IO_BASE+k.
  - Output j: IO_BASE+NUM_IN+j.
  - 2^ADDR_W-1: reserved.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- addr  in  ADDR_W  core address
- rd_en  in  1  core read strobe; pops input channels
- wr_en  in  1  core write strobe
- data_in  in  DATA_W  core write data
- data_out  out  DATA_W  combinational read data
- stall  out  1  combinational; core must hold addr/rd_en/wr_en/data_in and retry
- in_data  in  NUM_IN*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- in_valid  in  NUM_IN  producer valid
- in_ready  out  NUM_IN  buffer can accept
- out_data  out  NUM_OUT*DATA_W  holding registers
- out_valid  out  NUM_OUT  holding register full
- out_ready  in  NUM_OUT  consumer accepts

Behaviour:
- Clock and reset: clk, rst_n synchronous active-low. All state updates on posedge clk.
- Reset values: in_buf_full=0, in_buf=0, out_valid=0, out_data=0. RAM contents are not reset.
- in_ready: equals rst_n & ~in_buf_full[k], so it is 0 while in reset.
- Read path: combinational, zero latency.
  - RAM address: data_out = mem[addr].
  - Input k: data_out = in_buf[k] if full, else 0.
  - Output addresses and reserved address: data_out = 0.
- RAM write: wr_en && addr<IO_BASE writes mem[addr] at the edge. Never stalls.
- Input channel k:
  - Push: in_valid[k] && in_ready[k] loads in_buf[k] from in_data and sets full.
  - Pop: rd_en && addr==IO_BASE+k && full, with no stall, clears full at the edge.
  - Empty read: rd_en on an empty channel raises stall=1. There is no pop and no state change.
  - Push and pop never coincide, because in_ready=0 while full. in_ready rises the cycle after a pop. Max throughput is 1 word per 2 cycles per channel.
- Output channel j:
  - Transfer: out_valid && out_ready clears out_valid at the edge.
  - Write: wr_en && addr==IO_BASE+NUM_IN+j is accepted when ~out_valid | out_ready. It loads out_data and sets out_valid=1. When it coincides with a transfer, the new value wins and valid stays 1.
  - Blocked write: out_valid && ~out_ready raises stall=1 and ignores the write.
  - out_data holds its value after transfer until the next write.
- Stall and access rules:
  - stall = (empty-input read) | (blocked-output write). It is never asserted for RAM or reserved addresses.
  - A stalled access has no side effects.
  - rd_en on an output address, or wr_en on an input address, is ignored, with no stall.
  - Reserved address: reads 0, writes ignored.
  - rd_en and wr_en both set on one input address: the pop occurs and the write is ignored.
- Reset mid-operation: buffered input words and pending output words are discarded. The handshakes restart from the empty state.

Test Plan:
- RAM: write 0x5A to addr 0 and 0xC3 to addr 252 -> reads return 0x5A and 0xC3. Read of 255 -> 0x00. Write 0x11 to 255 and to 253 -> no state change, stall=0.
- Input: in_valid=1 with in_data=0x42 for 1 cycle -> next cycle in_ready=0. rd_en @253 -> data_out=0x42, stall=0. Next cycle in_ready=1. A second rd_en @253 -> stall=1, data_out=0x00.
- Output: write 0x7E @254 with out_ready=0 -> out_valid=1, out_data=0x7E. Write 0x01 @254 -> stall=1 and out_data stays 0x7E. Raise out_ready in the same cycle -> write accepted, out_data=0x01, out_valid=1.
- Multi-channel (NUM_IN=2, NUM_OUT=2): IO_BASE=251. Channels 0 and 1 loaded with 0xA0/0xA1 -> reads @251/@252 return 0xA0/0xA1. Writes @253/@254 drive out_data[7:0] and out_data[15:8] independently.
- Reset mid-operation: input buffer full and out_valid=1, then rst_n=0 for 1 cycle -> in_ready=0 during reset. Afterwards out_valid=0, out_data=0, in_ready=1, and rd_en @253 -> stall=1. RAM retains 0x5A at addr 0.
- ADDR_W=10, DATA_W=16: IO_BASE=1021. Write 0xBEEF @1020 -> read back 0xBEEF. An input word 0x1234 reads @1021.
